// File: rtl/reg_file.sv
// reg_file: 2**ADDR_W x DATA_W register file; clk/reset (sync, active-high), one write port (LdReg/WtAdrs/WtData), two async read ports (RdAdrsA->RdDataA, RdAdrsB->RdDataB), no write-through
module reg_file #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              LdReg,
  input  logic [ADDR_W-1:0] WtAdrs,
  input  logic [DATA_W-1:0] WtData,
  input  logic [ADDR_W-1:0] RdAdrsA,
  input  logic [ADDR_W-1:0] RdAdrsB,
  output logic [DATA_W-1:0] RdDataA,
  output logic [DATA_W-1:0] RdDataB
);
  logic [DATA_W-1:0] regs [2**ADDR_W];
  always_ff @(posedge clk)
    if (reset) regs <= '{default: '0};
    else if (LdReg) regs[WtAdrs] <= WtData;
  assign RdDataA = regs[RdAdrsA];
  assign RdDataB = regs[RdAdrsB];
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file
module tb_reg_file;
  logic       clk = 0;
  logic       reset = 0;
  logic       LdReg = 0;
  logic [2:0] WtAdrs = '0;
  logic [7:0] WtData = '0;
  logic [2:0] RdAdrsA = '0;
  logic [2:0] RdAdrsB = '0;
  logic [7:0] RdDataA;
  logic [7:0] RdDataB;
  logic [7:0] m [8];
  int checks = 0;
  int errors = 0;
  reg_file #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .LdReg(LdReg), .WtAdrs(WtAdrs), .WtData(WtData),
    .RdAdrsA(RdAdrsA), .RdAdrsB(RdAdrsB), .RdDataA(RdDataA), .RdDataB(RdDataB)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    LdReg = 1;
    WtAdrs = a;
    WtData = d;
    edge1();
    LdReg = 0;
  endtask
  task automatic do_reset(input int n);
    reset = 1;
    repeat (n) edge1();
    reset = 0;
  endtask
  initial begin
    do_reset(10);
    for (int i = 0; i < 8; i++) begin
      RdAdrsA = 3'(i);
      RdAdrsB = 3'(7 - i);
      #1;
      check("reset_sweep_a", RdDataA, 8'h00);
      check("reset_sweep_b", RdDataB, 8'h00);
    end
    for (int i = 0; i < 8; i++) begin
      m[i] = 8'($urandom);
      wr(3'(i), m[i]);
      RdAdrsA = 3'(i);
      RdAdrsB = 3'(i);
      #1;
      check("write_a", RdDataA, m[i]);
      check("write_b", RdDataB, m[i]);
      for (int j = 0; j < i; j++) begin
        RdAdrsB = 3'(j);
        #1;
        check("keep_prior", RdDataB, m[j]);
      end
    end
    wr(3'd3, 8'hA5);
    wr(3'd5, 8'h5A);
    RdAdrsA = 3'd3;
    RdAdrsB = 3'd5;
    #1;
    check("pair_a3", RdDataA, 8'hA5);
    check("pair_b5", RdDataB, 8'h5A);
    RdAdrsA = 3'd5;
    RdAdrsB = 3'd3;
    #1;
    check("swap_a5", RdDataA, 8'h5A);
    check("swap_b3", RdDataB, 8'hA5);
    RdAdrsA = 3'd1;
    RdAdrsB = 3'd1;
    #1;
    check("same_addr_a", RdDataA, m[1]);
    check("same_addr_b", RdDataB, m[1]);
    do_reset(1);
    LdReg = 0;
    WtAdrs = 3'd2;
    WtData = 8'hFF;
    repeat (4) edge1();
    RdAdrsA = 3'd2;
    #1;
    check("no_ld_r2", RdDataA, 8'h00);
    wr(3'd4, 8'h11);
    RdAdrsA = 3'd4;
    #1;
    check("r4_pre_reset", RdDataA, 8'h11);
    wr(3'd7, 8'hC3);
    reset = 1;
    LdReg = 1;
    WtAdrs = 3'd4;
    WtData = 8'h77;
    edge1();
    reset = 0;
    LdReg = 0;
    check("reset_beats_write", RdDataA, 8'h00);
    RdAdrsB = 3'd7;
    #1;
    check("reset_clears_r7", RdDataB, 8'h00);
    RdAdrsA = 3'd6;
    LdReg = 1;
    WtAdrs = 3'd6;
    WtData = 8'h3C;
    #1;
    check("no_bypass_before", RdDataA, 8'h00);
    edge1();
    LdReg = 0;
    check("no_bypass_after", RdDataA, 8'h3C);
    LdReg = 1;
    WtAdrs = 3'd1;
    WtData = 8'h80;
    edge1();
    WtAdrs = 3'd2;
    WtData = 8'h7F;
    edge1();
    WtAdrs = 3'd1;
    WtData = 8'hFE;
    edge1();
    LdReg = 0;
    RdAdrsA = 3'd1;
    RdAdrsB = 3'd2;
    #1;
    check("b2b_overwrite_r1", RdDataA, 8'hFE);
    check("b2b_r2", RdDataB, 8'h7F);
    wr(3'd0, 8'hFF);
    repeat (20) edge1();
    RdAdrsA = 3'd0;
    RdAdrsB = 3'd6;
    #1;
    check("r0_writable", RdDataA, 8'hFF);
    check("retain_r6", RdDataB, 8'h3C);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DATA_W, default 8, width of each register and of the data ports.
REQ-002 Parameter ADDR_W, default 3, address width; register count SHALL be 2**ADDR_W (8 by default).
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 LdReg  input  1  write enable; high at a rising edge commits WtData to register WtAdrs.
REQ-006 WtAdrs  input  ADDR_W  write address.
REQ-007 WtData  input  DATA_W  write data.
REQ-008 RdAdrsA  input  ADDR_W  read address, port A.
REQ-009 RdAdrsB  input  ADDR_W  read address, port B.
REQ-010 RdDataA  output  DATA_W  contents of register RdAdrsA.
REQ-011 RdDataB  output  DATA_W  contents of register RdAdrsB.
REQ-012 The block SHALL use one clock; reset is synchronous and active-high, ports named clk and reset.

Function
REQ-013 The block SHALL hold 2**ADDR_W registers of DATA_W bits, all general purpose; register 0 SHALL be writable and readable like any other (not hardwired to zero).
REQ-014 Write: at a rising clk edge with reset=0 and LdReg=1, register[WtAdrs] SHALL take WtData; all other registers SHALL hold.
REQ-015 With LdReg=0, no register SHALL change; WtAdrs/WtData SHALL be ignored.
REQ-016 Read ports SHALL be combinational (asynchronous): RdDataA = register[RdAdrsA], RdDataB = register[RdAdrsB], with zero clock latency after an address change.
REQ-017 Ports A and B SHALL be independent; equal addresses on A and B SHALL both return the same value.
REQ-018 No write-through bypass: while a write to address X is pending in the same cycle, a read of X SHALL return the old value until the rising edge, then the new value.
REQ-019 Write data SHALL be stored unmodified at full DATA_W; no sign extension, truncation or arithmetic.
REQ-020 Every address value is valid (ADDR_W fully decodes); no out-of-range handling is needed.
REQ-021 Back-to-back writes on consecutive edges SHALL each commit; a later write to the same address SHALL overwrite the earlier one.

Reset
REQ-022 At a rising edge with reset=1, every register SHALL become 0, so RdDataA and RdDataB SHALL read 0 for every address.
REQ-023 reset SHALL take priority over LdReg: a write in a reset cycle SHALL be discarded.
REQ-024 Reset asserted mid-operation SHALL clear all previously written contents at the next edge; with reset=0 the registers SHALL be retained indefinitely.
REQ-025 Before the first reset edge, register contents are undefined; the bench SHALL apply reset for at least one edge before checking.

Verification
REQ-026 Reset 10 cycles, release, sweep RdAdrsA/RdAdrsB over 0..7 -> both outputs 8'h00 at every address.
REQ-027 For i=0..7: WtAdrs=i, WtData=random, LdReg=1 for one edge, then LdReg=0; RdAdrsA=RdAdrsB=i -> both outputs equal the written byte one cycle later; earlier addresses keep their values.
REQ-028 Write 8'hA5 to r3 and 8'h5A to r5; RdAdrsA=3, RdAdrsB=5 -> RdDataA=8'hA5, RdDataB=8'h5A; swap addresses -> outputs swap immediately, no clock needed.
REQ-029 LdReg=0, WtAdrs=2, WtData=8'hFF over several edges -> r2 remains at its prior value (8'h00 after reset).
REQ-030 Write 8'h11 to r4, then drive reset=1 and LdReg=1 with WtData=8'h77 to r4 in the same cycle -> after the edge r4 reads 8'h00.
REQ-031 RdAdrsA=6 while writing 8'h3C to r6 (old value 8'h00) -> RdDataA=8'h00 before the edge, 8'h3C after it.
